// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles {opcode,arg} words into a small program RAM
// that the CPU reads combinationally by pc.
module program_loader #(
    parameter int          ADDR_BITS = 4,
    parameter int          WORD_BITS = 10,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_BITS-1:0] pc,
    output logic [WORD_BITS-1:0] statement,
    output logic                 loading,
    output logic                 done,
    output logic                 error,
    output logic                 program_valid,
    output logic [ADDR_BITS:0]   word_count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // the source holds in_byte stable until then. in_ready drops only in WRITE.
    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE, CHECK} state_t;

    state_t               state, state_next;
    logic [WORD_BITS-1:0] ram [DEPTH];
    logic [ADDR_BITS:0]   n_words;
    logic [ADDR_BITS:0]   wc_next;
    logic [7:0]           checksum;
    logic [1:0]           word_hi;
    logic [7:0]           word_lo;
    logic                 accept;
    logic                 count_bad;
    logic                 hi_bad;

    assign statement = ram[pc];
    assign wc_next   = word_count + {{ADDR_BITS{1'b0}}, 1'b1};
    assign count_bad = (in_byte == 8'd0) || (in_byte > 8'(DEPTH));
    assign hi_bad    = |in_byte[7:2];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept && in_byte == HEADER) state_next = COUNT;
            COUNT: if (accept) state_next = count_bad ? IDLE : HI;
            HI:    if (accept) state_next = hi_bad ? IDLE : LO;
            LO:    if (accept) state_next = WRITE;
            WRITE: state_next = (wc_next == n_words) ? CHECK : HI;
            CHECK: if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state != WRITE);
        accept   = in_valid && in_ready;
    end

    // Datapath and status flags; words already written on a failed frame are kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            loading       <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            program_valid <= 1'b0;
            word_count    <= '0;
            n_words       <= '0;
            checksum      <= '0;
            word_hi       <= '0;
            word_lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && in_byte == HEADER) begin
                        loading       <= 1'b1;
                        error         <= 1'b0;
                        program_valid <= 1'b0;
                        word_count    <= '0;
                        checksum      <= '0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        checksum <= checksum + in_byte;
                        if (count_bad) begin
                            error   <= 1'b1;
                            loading <= 1'b0;
                        end else begin
                            n_words <= in_byte[ADDR_BITS:0];
                        end
                    end
                end
                HI: begin
                    if (accept) begin
                        checksum <= checksum + in_byte;
                        if (hi_bad) begin
                            error   <= 1'b1;
                            loading <= 1'b0;
                        end else begin
                            word_hi <= in_byte[1:0];
                        end
                    end
                end
                LO: begin
                    if (accept) begin
                        checksum <= checksum + in_byte;
                        word_lo  <= in_byte;
                    end
                end
                WRITE: begin
                    ram[word_count[ADDR_BITS-1:0]] <= {word_hi, word_lo};
                    word_count <= wc_next;
                end
                CHECK: begin
                    if (accept) begin
                        loading <= 1'b0;
                        if (in_byte == checksum) begin
                            done          <= 1'b1;
                            program_valid <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames are driven byte by byte, expected RAM
// words queue up as they are sent and are compared when read back through pc.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] pc;
    logic [9:0] statement;
    logic       loading;
    logic       done;
    logic       error;
    logic       program_valid;
    logic [4:0] word_count;

    int checks   = 0;
    int failures = 0;
    int ready_low_cnt = 0;
    int stall_cnt     = 0;
    int done_cnt      = 0;

    logic [9:0] exp_q[$];
    logic [9:0] frame_words[16];

    program_loader dut (
        .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .pc(pc), .statement(statement), .loading(loading),
        .done(done), .error(error), .program_valid(program_valid),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (!in_ready) ready_low_cnt++;
            if (in_valid && !in_ready) stall_cnt++;
            if (done) done_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a byte after an optional idle gap and wait until it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        int t;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clock);
            #1;
        end
        in_byte  = b;
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (rdy) break;
            t++;
            if (t > 8) begin
                checks++;
                failures++;
                $error("FAIL accept_timeout observed=stalled expected=accept byte 0x%0h", b);
                break;
            end
        end
    endtask

    task automatic send_frame(input int n, input int max_gap, input bit bad_ck);
        logic [7:0] ck, hi, lo;
        int rl0, st0, d0;
        rl0 = ready_low_cnt;
        st0 = stall_cnt;
        d0  = done_cnt;
        send_byte(8'hA5, $urandom_range(0, max_gap));
        chk("loading_at_header", loading, 1);
        chk("error_cleared_at_header", error, 0);
        chk("valid_cleared_at_header", program_valid, 0);
        chk("word_count_cleared", word_count, 0);
        send_byte(n[7:0], $urandom_range(0, max_gap));
        ck = n[7:0];
        for (int i = 0; i < n; i++) begin
            hi = {6'b0, frame_words[i][9:8]};
            lo = frame_words[i][7:0];
            send_byte(hi, (i == 0) ? $urandom_range(0, max_gap) : 0);
            send_byte(lo, $urandom_range(0, max_gap));
            ck = ck + hi + lo;
            exp_q.push_back(frame_words[i]);
        end
        send_byte(bad_ck ? ~ck : ck, 0);
        in_valid = 1'b0;
        @(negedge clock);
        if (!bad_ck) begin
            chk("done_pulse", done, 1);
            chk("program_valid_good", program_valid, 1);
            chk("error_good", error, 0);
        end else begin
            chk("done_bad_ck", done, 0);
            chk("program_valid_bad_ck", program_valid, 0);
            chk("error_bad_ck", error, 1);
        end
        chk("loading_end", loading, 0);
        chk("word_count_end", word_count, n);
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt - d0, bad_ck ? 0 : 1);
        chk("ready_low_per_word", ready_low_cnt - rl0, n);
        chk("stall_per_word", stall_cnt - st0, n);
    endtask

    task automatic check_ram(input int n);
        for (int i = 0; i < n; i++) begin
            pc = i[3:0];
            @(negedge clock);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL scoreboard_empty observed=empty expected=word for pc %0d", i);
            end else begin
                chk($sformatf("ram[%0d]", i), statement, exp_q.pop_front());
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        pc       = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_loading", loading, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_program_valid", program_valid, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_statement", statement, 0);
        @(posedge clock);
        #1;

        // Good frame, in_valid held high.
        frame_words[0] = 10'h104;
        frame_words[1] = 10'h2A3;
        send_frame(2, 0, 1'b0);
        check_ram(2);
        pc = 4'd1;
        @(negedge clock);
        chk("pc1_statement", statement, 10'h2A3);
        @(posedge clock);
        #1;

        // Bad checksum: words still land in RAM.
        frame_words[0] = 10'h155;
        frame_words[1] = 10'h0AA;
        send_frame(2, 0, 1'b1);
        check_ram(2);

        // Illegal fields.
        send_byte(8'hA5, 0);
        chk("hdr_clears_error", error, 0);
        send_byte(8'h00, 0);
        chk("count_zero_error", error, 1);
        chk("count_zero_loading", loading, 0);
        send_byte(8'hA5, 0);
        chk("hdr_after_count0", loading, 1);
        send_byte(8'h11, 0);
        chk("count_17_error", error, 1);
        chk("count_17_loading", loading, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        chk("hi_04_error", error, 1);
        chk("hi_04_loading", loading, 0);
        in_valid = 1'b0;

        // Recovery frame overwrites only entry 0.
        frame_words[0] = 10'h3FF;
        send_frame(1, 0, 1'b0);
        check_ram(1);
        pc = 4'd1;
        @(negedge clock);
        chk("ram1_kept", statement, 10'h0AA);
        @(posedge clock);
        #1;

        // Random gaps, bytes after each LO held through the WRITE bubble.
        frame_words[0] = 10'h104;
        frame_words[1] = 10'h2A3;
        send_frame(2, 2, 1'b0);
        check_ram(2);

        // Garbage before the header, then a full-depth frame.
        send_byte(8'h00, 0);
        send_byte(8'h5A, 1);
        send_byte(8'hFF, 0);
        in_valid = 1'b0;
        @(negedge clock);
        chk("garbage_ignored", loading, 0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) frame_words[i] = 10'(i);
        send_frame(16, 0, 1'b0);
        check_ram(16);

        // Reset after the second data byte of a frame.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_loading", loading, 0);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        chk("midrst_program_valid", program_valid, 0);
        chk("midrst_word_count", word_count, 0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) exp_q.push_back(10'h000);
        check_ram(16);

        frame_words[0] = 10'h104;
        frame_words[1] = 10'h2A3;
        send_frame(2, 1, 1'b0);
        check_ram(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
